// File: rtl/prga.sv
// ARC4 pseudo-random generation stage: walks the key-scheduled S memory,
// swaps entries in place and XORs the keystream onto a length-prefixed message.
module prga (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    IDLE,
    RDL,
    LDL,
    WRL,
    RDI,
    LDI,
    RDJ,
    LDJ,
    WRI,
    WRJ,
    RDP,
    LDP,
    WRP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] k_q, k_d;
  logic [7:0] len_q, len_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [7:0] ctb_q, ctb_d;
  logic [7:0] pad_q, pad_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 8'd0;
      len_q   <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      ctb_q   <= 8'd0;
      pad_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      ctb_q   <= ctb_d;
      pad_q   <= pad_d;
    end
  end

  // Every memory has one cycle of read latency, so each read is split into an
  // address cycle (RDx) and a capture cycle (LDx).
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    ctb_d     = ctb_q;
    pad_d     = pad_q;
    rdy       = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;

    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          state_d = RDL;
        end
      end
      RDL: begin
        ct_addr = 8'd0;
        state_d = LDL;
      end
      LDL: begin
        len_d   = ct_rddata;
        state_d = LDL == LDL ? WRL : IDLE;
      end
      WRL: begin
        pt_addr   = 8'd0;
        pt_wrdata = len_q;
        pt_wren   = 1'b1;
        i_d       = 8'd0;
        j_d       = 8'd0;
        if (len_q == 8'd0) begin
          k_d     = 8'd0;
          state_d = IDLE;
        end else begin
          k_d     = 8'd1;
          state_d = RDI;
        end
      end
      RDI: begin
        s_addr  = i_q + 8'd1;
        i_d     = i_q + 8'd1;
        state_d = LDI;
      end
      LDI: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata;
        state_d = RDJ;
      end
      RDJ: begin
        s_addr  = j_q;
        state_d = LDJ;
      end
      LDJ: begin
        sj_d    = s_rddata;
        state_d = WRI;
      end
      // When i == j both writes carry the same value, so the swap is a no-op.
      WRI: begin
        s_addr   = i_q;
        s_wrdata = sj_q;
        s_wren   = 1'b1;
        state_d  = WRJ;
      end
      WRJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        ct_addr  = k_q;
        state_d  = RDP;
      end
      RDP: begin
        s_addr  = si_q + sj_q;
        ctb_d   = ct_rddata;
        state_d = LDP;
      end
      LDP: begin
        pad_d   = s_rddata;
        state_d = WRP;
      end
      WRP: begin
        pt_addr   = k_q;
        pt_wrdata = pad_q ^ ctb_q;
        pt_wren   = 1'b1;
        if (k_q == len_q) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = 8'd0;
          len_d   = 8'd0;
          state_d = IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = RDI;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
